// File: rtl/barrelshift_reg.sv
// Registered rotate-right barrel shifter.
// A log2(WIDTH)-stage mux network rotates the input right by ctrl positions,
// and a single output register captures the result every clock.
// Stage k rotates by 2**k when ctrl[k] is set.
module barrelshift_reg #(
  parameter  int WIDTH  = 8,
  localparam int CTRL_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]  out
);

  // stage[0] is the raw input; stage[CTRL_W] is the fully rotated word.
  logic [WIDTH-1:0] stage [0:CTRL_W];

  assign stage[0] = in;

  genvar k;
  generate
    for (k = 0; k < CTRL_W; k++) begin : g_stage
      localparam int SH = 2 ** k;
      logic [WIDTH-1:0] rotated;

      // Fixed rotate-right by 2**k: low bits wrap around into the top.
      assign rotated      = {stage[k][SH-1:0], stage[k][WIDTH-1:SH]};
      assign stage[k + 1] = ctrl[k] ? rotated : stage[k];
    end
  endgenerate

  // Output register: clears asynchronously, otherwise loads the rotated word every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= stage[CTRL_W];
    end
  end

endmodule

// File: tb/tb_barrelshift_reg.sv
// Directed and random-stimulus bench for barrelshift_reg.
module tb_barrelshift_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic [2:0] ctrl;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  barrelshift_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .ctrl  (ctrl),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotate-right: out[i] = in[(i + amt) mod 8].
  function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] amt);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[(i + int'(amt)) % 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply in/ctrl, let one rising edge capture them, then sample 1ns later.
  task automatic step(input logic [7:0] d, input logic [2:0] c,
                      input logic [7:0] exp, input string tag);
    in   = d;
    ctrl = c;
    @(posedge clk);
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    logic [7:0] prev_in;
    logic [2:0] prev_ctrl;

    rst_n = 1'b0;
    in    = 8'hFF;
    ctrl  = 3'd3;
    #1;
    check("reset_initial", out, 8'h00);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_load", out, 8'hFF);

    // Mid-operation reset pulse between edges.
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_low", out, 8'h00);
    rst_n = 1'b1;
    #2;
    check("reset_wait_edge", out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_first_edge", out, 8'hFF);

    step(8'h00, 3'd0, 8'h00, "zero_pass");
    step(8'hA5, 3'd0, 8'hA5, "a5_pass");

    step(8'd128, 3'd1, 8'd64, "walk_1");
    step(8'd128, 3'd2, 8'd32, "walk_2");
    step(8'd128, 3'd3, 8'd16, "walk_3");
    step(8'd128, 3'd4, 8'd8,  "walk_4");
    step(8'd128, 3'd5, 8'd4,  "walk_5");

    step(8'd255, 3'd7, 8'd255, "ones_rot7");
    step(8'd255, 3'd4, 8'd255, "ones_rot4");

    step(8'h81, 3'd1, 8'hC0, "wrap_81_r1");
    step(8'h01, 3'd7, 8'h02, "wrap_01_r7");
    step(8'h0F, 3'd4, 8'hF0, "wrap_0f_r4");
    step(8'hA5, 3'd1, 8'hD2, "a5_r1");
    step(8'h3C, 3'd6, 8'hF0, "3c_r6");

    // Back-to-back random traffic: each edge's result reflects that edge's inputs.
    prev_in   = $urandom_range(0, 255);
    prev_ctrl = $urandom_range(0, 7);
    in        = prev_in;
    ctrl      = prev_ctrl;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      check("random_rotate", out, rotr(prev_in, prev_ctrl));
      checks++;
      assert ($countones(out) == $countones(prev_in)) else begin
        errors++;
        $error("FAIL popcount: observed %0d expected %0d", $countones(out), $countones(prev_in));
      end
      prev_in   = $urandom_range(0, 255);
      prev_ctrl = $urandom_range(0, 7);
      in        = prev_in;
      ctrl      = prev_ctrl;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
